pwm_gen_multi: RTL and testbench

Parametrised multi-channel PWM generator, successor to the fixed 4-channel 8-bit RGBW PWM stage. It has N channels of WIDTH-bit resolution and an internal programmable prescaler. Duty registers are double-buffered, with a glitch-free commit at the period boundary, and channels can optionally start phase-staggered. It sits between the colour/data dispenser (write side) and the LED driver pins.

---
 rtl/pwm_pkg.sv | 20 ++
 rtl/pwm_gen_multi_if.sv | 27 ++
 rtl/pwm_prescaler.sv | 34 +++
 rtl/pwm_gen_multi.sv | 104 ++++++++++
 tb/tb_pwm_gen_multi.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// Shared elaboration-time helpers for the multi-channel PWM generator:
// address sizing, full-scale value and per-channel phase offsets.
package pwm_pkg;

  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

  // Full-scale duty / period length in ticks for a given resolution.
  function automatic int max_of(input int width);
    return (1 << width) - 1;
  endfunction

  function automatic int phase_offset(input int idx, input int channels, input int width);
    return idx * (max_of(width) / channels);
  endfunction

endpackage

// File: rtl/pwm_gen_multi_if.sv
// Write-side port bundle of the PWM generator: shadow duty writes plus commit control/status.
// wr_en and commit are single-cycle strobes that are always accepted (no ready/backpressure);
// commit_pending is a level, commit_done a one-cycle pulse when the shadows were applied.
interface pwm_gen_multi_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
);
  import pwm_pkg::*;
  localparam int AW = clog2_min1(CHANNELS);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             commit;
  logic             commit_pending;
  logic             commit_done;

  modport master (
    output wr_en, wr_addr, wr_data, commit,
    input  commit_pending, commit_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, commit,
    output commit_pending, commit_done
  );
endinterface

// File: rtl/pwm_prescaler.sv
// Programmable clock prescaler: emits one tick every presc_div_i+1 enabled cycles.
module pwm_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable_i,
  input  logic [PRESC_W-1:0] presc_div_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic               hit;

  // >= rather than == so a divider lowered below the running count ticks at once.
  assign hit = presc_cnt_q >= presc_div_i;

  always_comb begin
    tick_o      = enable_i && hit;
    presc_cnt_d = presc_cnt_q;
    if (enable_i) begin
      presc_cnt_d = hit ? '0 : presc_cnt_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_cnt_q <= '0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
    end
  end

endmodule

// File: rtl/pwm_gen_multi.sv
// N-channel PWM generator with prescaler, double-buffered duties committed only at the
// period boundary, optional per-channel phase stagger and selectable output polarity.
module pwm_gen_multi
  import pwm_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int PRESC_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PRESC_W-1:0]  presc_div,
  input  logic                stagger,
  input  logic                polarity,
  pwm_gen_multi_if.slave      bus,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_end
);

  localparam int               MAX    = max_of(WIDTH);
  localparam int               AW     = clog2_min1(CHANNELS);
  localparam logic [WIDTH-1:0] LAST   = WIDTH'(MAX - 1);
  localparam logic [WIDTH:0]   MAX1   = (WIDTH+1)'(MAX);
  localparam logic [AW:0]      CH_LIM = (AW+1)'(CHANNELS);

  logic                tick;
  logic                boundary;
  logic                copy;
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    shadow_q [CHANNELS];
  logic [WIDTH-1:0]    shadow_d [CHANNELS];
  logic [WIDTH-1:0]    active_q [CHANNELS];
  logic [WIDTH-1:0]    active_d [CHANNELS];
  logic                pending_q, pending_d;
  logic                done_q, done_d;
  logic                pe_q, pe_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic [CHANNELS-1:0] raw;

  pwm_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk        (clk),
    .reset      (reset),
    .enable_i   (enable),
    .presc_div_i(presc_div),
    .tick_o     (tick)
  );

  // tick already carries enable, so a frozen counter never reaches a boundary.
  assign boundary = tick && (cnt_q == LAST);
  assign copy     = boundary && (pending_q || bus.commit);

  always_comb begin
    cnt_d = cnt_q;
    if (tick) begin
      cnt_d = boundary ? '0 : cnt_q + WIDTH'(1);
    end
    pending_d = copy ? 1'b0 : (pending_q || bus.commit);
    done_d    = copy;
    pe_d      = boundary;
    // The copy reads shadow_q, so a same-cycle write lands only for the next commit.
    active_d  = copy ? shadow_q : active_q;
    shadow_d  = shadow_q;
    if (bus.wr_en && ({1'b0, bus.wr_addr} < CH_LIM)) begin
      shadow_d[bus.wr_addr] = bus.wr_data;
    end
    pwm_d = enable ? (raw ^ {CHANNELS{polarity}}) : {CHANNELS{polarity}};
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    localparam logic [WIDTH:0] OFF = (WIDTH+1)'(phase_offset(i, CHANNELS, WIDTH));
    logic [WIDTH:0] sum;
    logic [WIDTH:0] ph;
    assign sum    = {1'b0, cnt_q} + (stagger ? OFF : '0);
    assign ph     = (sum >= MAX1) ? (sum - MAX1) : sum;
    assign raw[i] = ph < {1'b0, active_q[i]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      shadow_q  <= '{default: '0};
      active_q  <= '{default: '0};
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      pe_q      <= 1'b0;
      pwm_q     <= '0;
    end else begin
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      pe_q      <= pe_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm_out            = pwm_q;
  assign period_end         = pe_q;
  assign bus.commit_pending = pending_q;
  assign bus.commit_done    = done_q;

endmodule

// File: tb/tb_pwm_gen_multi.sv
// Self-checking bench for pwm_gen_multi: directed period measurements plus a randomized
// run, all compared cycle by cycle against an arithmetic reference model.
module tb_pwm_gen_multi;
  import pwm_pkg::*;

  localparam int CH  = 4;
  localparam int W   = 8;
  localparam int PW  = 8;
  localparam int MAX = 255;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [PW-1:0] presc_div;
  logic          stagger;
  logic          polarity;
  logic [CH-1:0] pwm_out;
  logic          period_end;

  pwm_gen_multi_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

  pwm_gen_multi #(.CHANNELS(CH), .WIDTH(W), .PRESC_W(PW)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .presc_div (presc_div),
    .stagger   (stagger),
    .polarity  (polarity),
    .bus       (bus),
    .pwm_out   (pwm_out),
    .period_end(period_end)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int            n_tests = 0;
  int            n_fail  = 0;
  int            cd_count = 0;
  logic [CH-1:0] exp_q[$];
  logic          e_pe, e_cd, e_pend;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_pc, m_cnt, m_pending;
  int m_shadow[CH];
  int m_active[CH];

  task automatic model_update();
    logic [CH-1:0] nxt;
    int  off, tick, bnd, cp;
    bit  on;
    if (reset) begin
      m_pc = 0; m_cnt = 0; m_pending = 0;
      for (int i = 0; i < CH; i++) begin m_shadow[i] = 0; m_active[i] = 0; end
      exp_q.push_back('0);
      e_pe = 0; e_cd = 0; e_pend = 0;
      return;
    end
    tick = (enable && (m_pc >= presc_div)) ? 1 : 0;
    bnd  = (tick && (m_cnt == MAX - 1)) ? 1 : 0;
    for (int i = 0; i < CH; i++) begin
      off    = stagger ? i * (MAX / CH) : 0;
      on     = ((m_cnt + off) % MAX) < m_active[i];
      nxt[i] = enable ? (on ^ polarity) : polarity;
    end
    exp_q.push_back(nxt);
    cp   = (bnd && (m_pending || bus.commit)) ? 1 : 0;
    e_pe = bnd[0];
    e_cd = cp[0];
    if (cp) begin
      for (int i = 0; i < CH; i++) m_active[i] = m_shadow[i];
      m_pending = 0;
    end else if (bus.commit) begin
      m_pending = 1;
    end
    e_pend = m_pending[0];
    if (bus.wr_en && (int'(bus.wr_addr) < CH)) m_shadow[bus.wr_addr] = bus.wr_data;
    if (enable) begin
      m_pc = tick ? 0 : m_pc + 1;
      if (tick) m_cnt = (m_cnt + 1) % MAX;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_eq("pwm_out", pwm_out, exp_q.pop_front());
    check_eq("period_end", period_end, e_pe);
    check_eq("commit_done", bus.commit_done, e_cd);
    check_eq("commit_pending", bus.commit_pending, e_pend);
    if (bus.commit_done) cd_count++;
  endtask

  task automatic wr(input int addr, input int data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr[1:0];
    bus.wr_data = data[W-1:0];
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic do_commit();
    bus.commit = 1'b1;
    step();
    bus.commit = 1'b0;
  endtask

  task automatic wait_pe();
    int n = 0;
    do begin step(); n++; end while (!period_end && n < 3000);
    if (!period_end) check_eq("wait_pe_timeout", 0, 1);
  endtask

  int m_hi[CH];
  int m_rise[CH];
  int m_steps;

  // Steps from just after a period_end up to and including the next one.
  task automatic measure_period();
    logic [CH-1:0] prev;
    prev    = pwm_out ^ {CH{polarity}};
    m_steps = 0;
    for (int i = 0; i < CH; i++) begin m_hi[i] = 0; m_rise[i] = -1; end
    do begin
      step();
      m_steps++;
      for (int i = 0; i < CH; i++) begin
        if (pwm_out[i] ^ polarity) begin
          m_hi[i]++;
          if (!prev[i] && m_rise[i] < 0) m_rise[i] = m_steps;
        end
      end
      prev = pwm_out ^ {CH{polarity}};
    end while (!period_end && m_steps < 3000);
    if (!period_end) check_eq("period_timeout", 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int duty1[CH];
    int n;
    reset = 1'b1; enable = 1'b1; presc_div = '0; stagger = 1'b0; polarity = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.commit = 1'b0;
    repeat (3) step();
    check_eq("rst_pwm", pwm_out, 0);
    check_eq("rst_pe", period_end, 0);
    check_eq("rst_pending", bus.commit_pending, 0);
    check_eq("rst_done", bus.commit_done, 0);
    reset = 1'b0;

    // T1: four duties, one commit
    duty1 = '{0, 64, 128, 255};
    for (int i = 0; i < CH; i++) wr(i, duty1[i]);
    cd_count = 0;
    do_commit();
    check_eq("t1_pending", bus.commit_pending, 1);
    wait_pe();
    measure_period();
    check_eq("t1_period", m_steps, MAX);
    for (int i = 0; i < CH; i++) check_eq($sformatf("t1_hi%0d", i), m_hi[i], duty1[i]);
    check_eq("t1_done_count", cd_count, 1);

    // T2: prescaler /4
    presc_div = 8'd3;
    wr(0, 10);
    do_commit();
    wait_pe();
    measure_period();
    check_eq("t2_period", m_steps, 1020);
    check_eq("t2_hi0", m_hi[0], 40);

    // T3: stagger
    presc_div = 8'd0; stagger = 1'b1;
    for (int i = 0; i < CH; i++) wr(i, 32);
    do_commit();
    wait_pe();
    measure_period();
    for (int i = 0; i < CH; i++) begin
      check_eq($sformatf("t3_hi%0d", i), m_hi[i], 32);
      check_eq($sformatf("t3_rise%0d", i), m_rise[i], ((MAX - phase_offset(i, CH, W)) % MAX) + 1);
    end

    // T4: shadow write without commit, then commit at cnt=5
    stagger = 1'b0;
    wait_pe();
    repeat (20) step();
    wr(1, 200);
    wait_pe();
    for (int p = 0; p < 3; p++) begin
      measure_period();
      check_eq($sformatf("t4_hold%0d", p), m_hi[1], 32);
    end
    n = 0;
    while (m_cnt != 5 && n < 600) begin step(); n++; end
    check_eq("t4_cnt5_reached", m_cnt, 5);
    do_commit();
    check_eq("t4_pending", bus.commit_pending, 1);
    measure_period();
    check_eq("t4_done", bus.commit_done, 1);
    check_eq("t4_pending_clr", bus.commit_pending, 0);
    measure_period();
    check_eq("t4_hi1", m_hi[1], 200);

    // T5: write + commit on the boundary cycle
    n = 0;
    while (!(m_cnt == MAX - 1 && m_pc >= presc_div) && n < 600) begin step(); n++; end
    bus.wr_en = 1'b1; bus.wr_addr = 2'd2; bus.wr_data = 8'd77; bus.commit = 1'b1;
    step();
    bus.wr_en = 1'b0; bus.commit = 1'b0;
    check_eq("t5_pe", period_end, 1);
    check_eq("t5_done", bus.commit_done, 1);
    check_eq("t5_pending", bus.commit_pending, 0);
    measure_period();
    check_eq("t5_old_hi2", m_hi[2], 32);
    do_commit();
    wait_pe();
    measure_period();
    check_eq("t5_new_hi2", m_hi[2], 77);

    // T6: disable with active-low outputs, then async reset
    polarity = 1'b1;
    wait_pe();
    repeat (100) step();
    enable = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step();
      check_eq("t6_inactive", pwm_out, 4'hF);
    end
    enable = 1'b1;
    measure_period();
    check_eq("t6_stretched_period", 150 + m_steps, MAX + 50);
    do_commit();
    #2 reset = 1'b1;
    #1;
    check_eq("t6_async_pwm", pwm_out, 0);
    check_eq("t6_async_pending", bus.commit_pending, 0);
    check_eq("t6_async_done", bus.commit_done, 0);
    check_eq("t6_async_pe", period_end, 0);
    step();
    reset = 1'b0;
    step();

    // Randomized run against the model
    polarity = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 199) == 0) presc_div = 8'($urandom_range(0, 3));
      enable      = ($urandom_range(0, 19) != 0);
      bus.wr_en   = ($urandom_range(0, 7) == 0);
      bus.wr_addr = 2'($urandom_range(0, 3));
      bus.wr_data = 8'($urandom_range(0, 255));
      bus.commit  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 299) == 0) polarity = ~polarity;
      if ($urandom_range(0, 299) == 0) stagger  = ~stagger;
      reset       = ($urandom_range(0, 999) == 0);
      step();
    end
    reset = 1'b0; bus.wr_en = 1'b0; bus.commit = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
